// File: rtl/uart_rx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm_if
// Signal bundle between the receive engine and its environment.
//   Rx_EN             receiver enable (low forces the engine idle)
//   Rx_sample_ENABLE  one-clock pulse at 16x the baud rate
//   RxD               synchronized serial line, idle high
//   Rx_DATA           last received byte
//   Rx_VALID          one-clock strobe: an error-free byte is available
//   Rx_PERROR         parity error flag of the last completed frame
//   Rx_FERROR         framing error flag of the last completed frame
// The master drives the line side; the slave (the receive engine) drives
// the received-data side.
// ---------------------------------------------------------------------------
interface uart_rx_fsm_if;
    logic       Rx_EN;
    logic       Rx_sample_ENABLE;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    modport master (
        output Rx_EN,
        output Rx_sample_ENABLE,
        output RxD,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR
    );

    modport slave (
        input  Rx_EN,
        input  Rx_sample_ENABLE,
        input  RxD,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// UART receive engine for 8 data bits, even parity, 1 stop bit, with 16x
// oversampling. Every protocol action happens only on clock edges where the
// sample enable is high. Each bit is sampled at its midpoint (sample 7 of 16).
// The frame completes at the stop-bit midpoint and the engine returns to idle
// on that same edge, so a following start edge can be detected half a bit
// early.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   rx     uart_rx_fsm_if.slave bundle (enable, tick, line in; data/flags out)
// ---------------------------------------------------------------------------
module uart_rx_fsm (
    input  logic         clk,
    input  logic         reset,
    uart_rx_fsm_if.slave rx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] scnt_r;     // index of the last processed sample within the current bit
    logic [2:0] bcnt_r;     // data bit currently being received
    logic [7:0] shift_r;    // bits enter at the MSB, so after 8 shifts bit 0 sits at the LSB
    logic       par_r;      // captured parity bit
    logic [7:0] data_r;
    logic       valid_r;
    logic       perr_r;
    logic       ferr_r;
    logic [3:0] scnt_nxt_s; // index of the sample being processed on this tick
    logic       perr_nxt_s;
    logic       ferr_nxt_s;

    // Even parity: the 8 data bits plus the parity bit must XOR to zero.
    function automatic logic parity_error(input logic [7:0] data, input logic par);
        parity_error = (^data) ^ par;
    endfunction

    // Next sample index and the error flags a frame would complete with.
    always_comb begin
        scnt_nxt_s = scnt_r + 4'd1;
        perr_nxt_s = parity_error(shift_r, par_r);
        ferr_nxt_s = ~rx.RxD;
    end

    // Receive state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            scnt_r  <= 4'd0;
            bcnt_r  <= 3'd0;
            shift_r <= 8'h00;
            par_r   <= 1'b0;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            // The valid strobe lasts exactly one clock, ticks or not.
            valid_r <= 1'b0;
            if (!rx.Rx_EN) begin
                // Disabled: discard any partial frame; data and flags hold.
                state_r <= ST_IDLE;
                scnt_r  <= 4'd0;
                bcnt_r  <= 3'd0;
                shift_r <= 8'h00;
                par_r   <= 1'b0;
            end else if (rx.Rx_sample_ENABLE) begin
                case (state_r)
                    ST_IDLE: begin
                        // The detecting tick itself is sample 0 of the start bit.
                        if (!rx.RxD) begin
                            state_r <= ST_START;
                            scnt_r  <= 4'd0;
                            bcnt_r  <= 3'd0;
                        end else begin
                            scnt_r  <= 4'd0;
                        end
                    end
                    ST_START: begin
                        scnt_r <= scnt_nxt_s;
                        if ((scnt_nxt_s == 4'd7) && rx.RxD) begin
                            // Line back high at mid-start: a glitch, not a frame.
                            state_r <= ST_IDLE;
                            scnt_r  <= 4'd0;
                        end else if (scnt_nxt_s == 4'd15) begin
                            state_r <= ST_DATA;
                            bcnt_r  <= 3'd0;
                        end else begin
                            state_r <= ST_START;
                        end
                    end
                    ST_DATA: begin
                        scnt_r <= scnt_nxt_s;
                        if (scnt_nxt_s == 4'd7) begin
                            shift_r <= {rx.RxD, shift_r[7:1]};
                        end else if (scnt_nxt_s == 4'd15) begin
                            if (bcnt_r == 3'd7) begin
                                state_r <= ST_PARITY;
                            end else begin
                                bcnt_r <= bcnt_r + 3'd1;
                            end
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        scnt_r <= scnt_nxt_s;
                        if (scnt_nxt_s == 4'd7) begin
                            par_r <= rx.RxD;
                        end else if (scnt_nxt_s == 4'd15) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_PARITY;
                        end
                    end
                    ST_STOP: begin
                        if (scnt_nxt_s == 4'd7) begin
                            // Complete the frame at mid-stop and go idle on the same edge.
                            data_r  <= shift_r;
                            perr_r  <= perr_nxt_s;
                            ferr_r  <= ferr_nxt_s;
                            valid_r <= ~(perr_nxt_s | ferr_nxt_s);
                            state_r <= ST_IDLE;
                            scnt_r  <= 4'd0;
                            bcnt_r  <= 3'd0;
                        end else begin
                            scnt_r  <= scnt_nxt_s;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        scnt_r  <= 4'd0;
                        bcnt_r  <= 3'd0;
                    end
                endcase
            end else begin
                // Non-tick cycle: state and counters hold.
                state_r <= state_r;
            end
        end
    end

    assign rx.Rx_DATA   = data_r;
    assign rx.Rx_VALID  = valid_r;
    assign rx.Rx_PERROR = perr_r;
    assign rx.Rx_FERROR = ferr_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
// Drives directed and randomized serial frames into uart_rx_fsm. A reference
// model counts ticks since the start edge, records the line at each tick and
// derives the byte and flags from the samples at ticks 16(n+1)+7, 151 and
// 167. A compare process checks the DUT against the model on every negedge,
// plus literal expectations for the directed frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    logic clk = 1'b0;
    logic rst_n;

    uart_rx_fsm_if bus ();

    uart_rx_fsm dut (
        .clk   (clk),
        .reset (rst_n),
        .rx    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit         m_busy;
    int         m_idx;
    bit         m_samp [0:167];
    logic [7:0] e_data;
    bit         e_valid, e_perr, e_ferr, m_done;
    int         m_ticks;

    // Literal expectations {data, valid, perr, ferr}
    logic [10:0] lit_arr [0:15];
    int          lit_wr, lit_rd;
    bit          lit_mode, lit_reset_chk, fin_req;

    int n_cmp, n_err, n_valid, gap_idx, last_vt;
    bit gap_done;

    function automatic logic [7:0] model_byte();
        logic [7:0] b;
        for (int n = 0; n < 8; n++) b[n] = m_samp[16*(n+1)+7];
        return b;
    endfunction

    // Reference model: tick index arithmetic relative to the start edge.
    initial begin
        m_busy = 0; m_idx = 0; e_data = 8'h00; e_valid = 0; e_perr = 0; e_ferr = 0;
        m_done = 0; m_ticks = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_idx = 0; e_data = 8'h00; e_valid = 0;
                e_perr = 0; e_ferr = 0; m_done = 0;
            end else begin
                e_valid = 0;
                m_done  = 0;
                if (!bus.Rx_EN) begin
                    m_busy = 0;
                end else if (bus.Rx_sample_ENABLE) begin
                    m_ticks++;
                    if (!m_busy) begin
                        if (!bus.RxD) begin
                            m_busy = 1; m_idx = 0; m_samp[0] = 1'b0;
                        end
                    end else begin
                        m_idx++;
                        m_samp[m_idx] = bus.RxD;
                        if (m_idx == 7 && bus.RxD) begin
                            m_busy = 0;
                        end else if (m_idx == 167) begin
                            e_data  = model_byte();
                            e_perr  = (^e_data) ^ m_samp[151];
                            e_ferr  = !bus.RxD;
                            e_valid = !(e_perr || e_ferr);
                            m_done  = 1;
                            m_busy  = 0;
                        end
                    end
                end
            end
        end
    end

    // Compare process: DUT versus model every cycle, plus literal pins.
    initial begin
        bit fin_done;
        fin_done = 0;
        n_cmp = 0; n_err = 0; n_valid = 0; last_vt = 0; gap_done = 0; lit_rd = 0;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (bus.Rx_DATA !== e_data || bus.Rx_VALID !== e_valid ||
                bus.Rx_PERROR !== e_perr || bus.Rx_FERROR !== e_ferr) begin
                n_err++;
                $display("FAIL model_cmp t=%0t actual data=%h v=%b pe=%b fe=%b required data=%h v=%b pe=%b fe=%b",
                         $time, bus.Rx_DATA, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR,
                         e_data, e_valid, e_perr, e_ferr);
            end
            if (lit_reset_chk) begin
                n_cmp++;
                if ({bus.Rx_DATA, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR} !== 11'h000) begin
                    n_err++;
                    $display("FAIL reset_values t=%0t actual %h required 000", $time,
                             {bus.Rx_DATA, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR});
                end
            end
            if (m_done && lit_mode) begin
                n_cmp++;
                if (lit_rd >= lit_wr) begin
                    n_err++;
                    $display("FAIL frame_literal t=%0t actual unexpected frame required none", $time);
                end else begin
                    if ({bus.Rx_DATA, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR} !== lit_arr[lit_rd]) begin
                        n_err++;
                        $display("FAIL frame_literal#%0d actual {data,v,pe,fe}=%h required %h", lit_rd,
                                 {bus.Rx_DATA, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR}, lit_arr[lit_rd]);
                    end
                    lit_rd++;
                end
            end
            if (bus.Rx_VALID === 1'b1) begin
                n_valid++;
                if (n_valid == gap_idx) begin
                    n_cmp++;
                    gap_done = 1;
                    if (m_ticks - last_vt != 168) begin
                        n_err++;
                        $display("FAIL valid_gap actual %0d ticks required 168", m_ticks - last_vt);
                    end
                end
                last_vt = m_ticks;
            end
            if (fin_req && !fin_done) begin
                fin_done = 1;
                n_cmp++;
                if (lit_rd != 9 || lit_wr != 9 || !gap_done) begin
                    n_err++;
                    $display("FAIL literal_coverage actual frames=%0d/%0d gap=%0b required 9/9 gap=1",
                             lit_rd, lit_wr, gap_done);
                end
            end
        end
    end

    // One tick on the line, then 0..2 idle clocks with the line held.
    task automatic tick_once(input logic v);
        bus.RxD = v;
        bus.Rx_sample_ENABLE = 1'b1;
        @(posedge clk); #1;
        bus.Rx_sample_ENABLE = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bits(input logic v, input int n);
        repeat (n) tick_once(v);
    endtask

    task automatic push_lit(input logic [7:0] d, input logic pe, input logic fe);
        lit_arr[lit_wr] = {d, ~(pe | fe), pe, fe};
        lit_wr++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int tail);
        send_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(d[i], 16);
        send_bits(p, 16);
        send_bits(s, 8);
        send_bits(1'b1, tail);
    endtask

    // Start bit plus the first four data bits: ticks 0..79 of a frame.
    task automatic send_partial(input logic [7:0] d);
        send_bits(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bits(d[i], 16);
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;
        int         r;
        rst_n = 1'b0;
        bus.Rx_EN = 1'b1; bus.Rx_sample_ENABLE = 1'b0; bus.RxD = 1'b1;
        lit_wr = 0; lit_mode = 1; lit_reset_chk = 1; fin_req = 0; gap_idx = -1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 lit_reset_chk = 0;

        push_lit(8'h55, 1'b0, 1'b0); send_frame(8'h55, 1'b0, 1'b1, 5);
        push_lit(8'h01, 1'b1, 1'b0); send_frame(8'h01, 1'b0, 1'b1, 5);
        push_lit(8'h01, 1'b0, 1'b0); send_frame(8'h01, 1'b1, 1'b1, 5);
        push_lit(8'hA5, 1'b0, 1'b1); send_frame(8'hA5, 1'b0, 1'b0, 40);
        send_bits(1'b0, 4); send_bits(1'b1, 20);
        push_lit(8'h3C, 1'b0, 1'b0); send_frame(8'h3C, 1'b0, 1'b1, 5);
        gap_idx = n_valid + 2;
        push_lit(8'h12, 1'b0, 1'b0); send_frame(8'h12, 1'b0, 1'b1, 0);
        push_lit(8'h34, 1'b0, 1'b0); send_frame(8'h34, 1'b1, 1'b1, 5);

        send_partial(8'hF0);
        rst_n = 1'b0; lit_reset_chk = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; bus.RxD = 1'b1;
        repeat (2) @(posedge clk);
        #1 lit_reset_chk = 0;
        send_bits(1'b1, 5);
        push_lit(8'hF0, 1'b0, 1'b0); send_frame(8'hF0, 1'b0, 1'b1, 5);

        send_partial(8'h0F);
        bus.Rx_EN = 1'b0;
        send_bits(1'b0, 3);
        bus.Rx_EN = 1'b1;
        send_bits(1'b1, 5);
        push_lit(8'hF0, 1'b0, 1'b0); send_frame(8'hF0, 1'b0, 1'b1, 5);
        lit_mode = 0;

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            p = ^d;
            if ($urandom_range(0, 4) == 0) p = ~p;
            s = ($urandom_range(0, 6) != 0);
            if (r == 0) begin
                send_bits(1'b0, $urandom_range(1, 7));
                send_bits(1'b1, $urandom_range(9, 20));
            end else if (r == 1) begin
                send_bits(1'b0, 1);
                repeat ($urandom_range(1, 160)) tick_once(1'($urandom));
                bus.Rx_EN = 1'b0;
                repeat (3) tick_once(1'($urandom));
                bus.Rx_EN = 1'b1;
                send_bits(1'b1, 20);
            end else begin
                send_frame(d, p, s, $urandom_range(0, 20));
            end
        end

        bus.RxD = 1'b1;
        repeat (20) @(posedge clk);
        #1 fin_req = 1;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Serial-to-parallel UART receive engine, directly downstream of the receive-channel synchronizer. Consumes the already-synchronized serial line and a 16x-baud sample enable from the baud controller. Frames 8N-even-1 characters: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit. Presents the received byte with a one-cycle valid strobe and sticky-per-frame parity and framing error flags.

## Interface
- No parameters; frame format and oversampling (16) are fixed.
- clk  in  1  system clock
- reset  in  1  active-low async reset (`reset`): one clock; reset is asynchronous and active-low.
- Rx_EN  in  1  receiver enable; low forces IDLE.
- Rx_sample_ENABLE  in  1  one-clk pulse at 16x baud rate; all protocol actions occur only on clk edges where this is 1.
- RxD  in  1  synchronized serial line, idle high.
- Rx_DATA  out  8  last received byte.
- Rx_VALID  out  1  one-clk pulse: error-free byte available.
- Rx_PERROR  out  1  parity error flag of last completed frame.
- Rx_FERROR  out  1  framing error flag of last completed frame.

## Operation
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, state=IDLE, sample counter=0, bit counter=0.
- 4-bit sample counter `scnt` (0..15) advances on each tick outside IDLE; wraps 15->0 at bit boundary.
- 3-bit data bit counter `bcnt` (0..7).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on tick with RxD=0 -> START, scnt=0; this tick is sample 0.
- START: at scnt=7, if RxD=1 -> IDLE (glitch rejection, no output change); at scnt=15 -> DATA, bcnt=0.
- DATA: at scnt=7, shift RxD into MSB of shift register (LSB-first reception); at scnt=15, if bcnt=7 -> PARITY else bcnt+1.
- PARITY: at scnt=7 capture parity bit; at scnt=15 -> STOP.
- STOP: at scnt=7 complete the frame and return to IDLE on the same edge:
  - Rx_DATA <= shift register, always.
  - Rx_PERROR <= (XOR of 8 data bits) XOR parity bit (expect 0).
  - Rx_FERROR <= (RxD==0).
  - Rx_VALID <= 1 only if both new flags are 0.
- Rx_VALID drops to 0 on the following clk edge regardless of ticks.
- Error flags hold until the next completed frame overwrites them. A glitch-rejected start does not change them.
- Rx_EN=0: state->IDLE, counters cleared, partial byte discarded; Rx_DATA and flags hold; Rx_VALID=0.
- Reset asserted mid-frame: all registers go to reset values immediately, without waiting for clk.
- Ticks are ignored while RxD is high in IDLE. Non-tick cycles never change state or counters.

## Timing
- The start-detect tick is index 0.
- Data bit n is sampled at tick 16(n+1)+7.
- The parity bit is sampled at tick 151.
- The stop bit is sampled at tick 167.
- Rx_VALID/Rx_DATA/flags update on the clk edge of tick 167 and are visible in the following cycle. Rx_VALID is high for exactly 1 clk.
- Returning to IDLE at mid-stop allows a new start edge to be detected from tick 168 onward, which tolerates up to about half a bit of baud mismatch.
- Back-to-back frames impose no dead time beyond the remaining half stop bit.
- Rx_sample_ENABLE is assumed to be no more than 1 clk wide. Consecutive-cycle ticks are legal and are processed each cycle.

## Test plan
- Send 0x55, parity 0, stop 1 -> at tick 167 Rx_DATA=0x55, one Rx_VALID pulse, PERROR=0, FERROR=0.
- Send 0x01 with parity 0 (wrong) -> Rx_DATA=0x01, PERROR=1, FERROR=0, no Rx_VALID. Then send 0x01 with parity 1 -> VALID pulse, PERROR back to 0.
- Send 0xA5, correct parity, stop bit 0 -> FERROR=1, no VALID. Then feed an idle-high line -> FERROR stays 1 until the next frame.
- RxD low for 4 ticks then high -> returns to IDLE at scnt=7, no output change. A following valid 0x3C frame is received correctly.
- Two back-to-back frames 0x12, 0x34 with the start edge immediately after the stop midpoint -> two VALID pulses, exactly 168 ticks apart if the start is detected at tick 168.
- Assert reset at tick 80 of a frame, or drop Rx_EN at tick 80 -> outputs per reset/hold rules, no VALID. After release, the next frame 0xF0 is received correctly.
